// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register select codes, register bit positions and
// exception codes used by the write-back stage CP0 logic.
package cp0_regfile_pkg;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_IP7  = 15;
  localparam int EXCODE_MSB = 6;
  localparam int EXCODE_LSB = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a
  } exc_code_e;

  // Only address errors latch a faulting address into BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every other cycle and raises TI
// when the advanced value matches Compare.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        tick;
  logic [31:0] count_inc;

  assign count_inc = count + 32'd1;

  // A software Count write replaces the increment, and a Compare write
  // clearing TI takes precedence over a match on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick    <= 1'b0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      tick <= ~tick;
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= count_inc;
      if (compare_we)
        compare <= wdata;
      if (compare_we)
        ti <= 1'b0;
      else if (tick && !count_we && (count_inc == compare))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// Write-back stage CP0: mtc0/mfc0 access, exception and eret commit, and
// the flush/redirect toward the front of the pipeline.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = 32'hbfc0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        ex_from_ws,
  output logic [31:0] ex_target,
  output logic        has_int
);

  logic        ev_ex, ev_eret, ev_mtc0;
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_excode;
  logic [31:0] epc, badvaddr;
  logic [31:0] count, compare;
  logic        ti;
  logic [31:0] status_val, cause_val;

  // An exception suppresses eret and mtc0; eret suppresses mtc0.
  assign ev_ex   = ws_valid & ws_ex;
  assign ev_eret = ws_valid & ws_eret & ~ws_ex;
  assign ev_mtc0 = ws_valid & mtc0_we & ~ws_ex & ~ws_eret;

  cp0_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .count_we  (ev_mtc0 && (cp0_addr == CR_COUNT)),
    .compare_we(ev_mtc0 && (cp0_addr == CR_COMPARE)),
    .wdata     (cp0_wdata),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );

  // A nested exception (EXL already set) keeps the original EPC and BD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_im    <= '0;
      status_exl   <= 1'b0;
      status_ie    <= 1'b0;
      cause_bd     <= 1'b0;
      cause_ip_sw  <= '0;
      cause_excode <= '0;
      epc          <= '0;
      badvaddr     <= '0;
    end else if (ev_ex) begin
      cause_excode <= ws_excode;
      status_exl   <= 1'b1;
      if (!status_exl) begin
        epc      <= ws_bd ? ws_pc - 32'd4 : ws_pc;
        cause_bd <= ws_bd;
      end
      if (is_addr_exc(ws_excode))
        badvaddr <= ws_badvaddr;
    end else if (ev_eret) begin
      status_exl <= 1'b0;
    end else if (ev_mtc0) begin
      case (cp0_addr)
        CR_STATUS: begin
          status_im  <= cp0_wdata[15:8];
          status_exl <= cp0_wdata[STATUS_EXL];
          status_ie  <= cp0_wdata[STATUS_IE];
        end
        CR_CAUSE: cause_ip_sw <= cp0_wdata[9:8];
        CR_EPC:   epc         <= cp0_wdata;
        default:  ;
      endcase
    end
  end

  always_comb begin
    status_val                         = '0;
    status_val[STATUS_BEV]             = 1'b1;
    status_val[15:8]                   = status_im;
    status_val[STATUS_EXL]             = status_exl;
    status_val[STATUS_IE]              = status_ie;
    cause_val                          = '0;
    cause_val[CAUSE_BD]                = cause_bd;
    cause_val[CAUSE_TI]                = ti;
    cause_val[CAUSE_IP7]               = ti;
    cause_val[9:8]                     = cause_ip_sw;
    cause_val[EXCODE_MSB:EXCODE_LSB]   = cause_excode;
  end

  always_comb begin
    case (cp0_addr)
      CR_BADVADDR: cp0_rdata = badvaddr;
      CR_COUNT:    cp0_rdata = count;
      CR_COMPARE:  cp0_rdata = compare;
      CR_STATUS:   cp0_rdata = status_val;
      CR_CAUSE:    cp0_rdata = cause_val;
      CR_EPC:      cp0_rdata = epc;
      default:     cp0_rdata = '0;
    endcase
  end

  assign ex_from_ws = ev_ex | ev_eret;
  assign ex_target  = ev_ex ? EX_ENTRY : epc;
  assign has_int    = (|(cause_val[15:8] & status_im)) & status_ie & ~status_exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized scoreboard bench for cp0_regfile against a field-level model of
// the CP0 registers and timer.
module tb_cp0_regfile;

  localparam logic [4:0] A_BADV = 5'd8,  A_COUNT = 5'd9,  A_COMP = 5'd11;
  localparam logic [4:0] A_STAT = 5'd12, A_CAUSE = 5'd13, A_EPC  = 5'd14;
  localparam logic [31:0] VEC   = 32'hbfc0_0380;

  logic        clk, reset;
  logic        ws_valid, ws_ex, ws_bd, ws_eret, mtc0_we;
  logic [4:0]  ws_excode, cp0_addr;
  logic [31:0] ws_pc, ws_badvaddr, cp0_wdata;
  logic [31:0] cp0_rdata, ex_target;
  logic        ex_from_ws, has_int;

  cp0_regfile dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_ex(ws_ex),
    .ws_excode(ws_excode), .ws_bd(ws_bd), .ws_pc(ws_pc),
    .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret), .mtc0_we(mtc0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .ex_from_ws(ex_from_ws), .ex_target(ex_target), .has_int(has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] rdata;
    logic        ex;
    logic [31:0] target;
    logic        hint;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_fail = 0;

  // Reference model state, held as individual architectural fields.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti, m_tick;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_badv, m_count, m_comp;

  function automatic void modelReset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_tick = 0;
    m_ipsw = '0; m_code = '0; m_epc = '0; m_badv = '0; m_count = '0; m_comp = '0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      A_BADV:  return m_badv;
      A_COUNT: return m_count;
      A_COMP:  return m_comp;
      A_STAT:  return 32'h0040_0000 + 32'(m_im) * 256 + 32'(m_exl) * 2 + 32'(m_ie);
      A_CAUSE: return 32'(m_bd) * 32'h8000_0000 + 32'(m_ti) * 32'h4000_0000
                    + 32'(m_ti) * 32'h8000 + 32'(m_ipsw) * 256 + 32'(m_code) * 4;
      A_EPC:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic modelHasInt();
    logic [7:0] pend;
    pend = {m_ti, 5'b0, m_ipsw};
    return ((pend & m_im) != 8'h0) && m_ie && !m_exl;
  endfunction

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (cp0_rdata !== e.rdata) begin
      n_fail++;
      $display("[TB] FAIL rdata addr=%0d: got %h expected %h", e.addr, cp0_rdata, e.rdata);
    end
    n_vec++;
    if (ex_from_ws !== e.ex) begin
      n_fail++;
      $display("[TB] FAIL ex_from_ws: got %b expected %b", ex_from_ws, e.ex);
    end
    if (e.ex) begin
      n_vec++;
      if (ex_target !== e.target) begin
        n_fail++;
        $display("[TB] FAIL ex_target: got %h expected %h", ex_target, e.target);
      end
    end
    n_vec++;
    if (has_int !== e.hint) begin
      n_fail++;
      $display("[TB] FAIL has_int: got %b expected %b", has_int, e.hint);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic applyStimulus(input logic v, input logic ex, input logic [4:0] code,
                               input logic bd, input logic [31:0] pc, input logic [31:0] badv,
                               input logic er, input logic mt, input logic [4:0] addr,
                               input logic [31:0] wd);
    exp_t e;
    logic do_ex, do_er, do_mt, cnt_wr;
    @(posedge clk); #1;
    reset = 0;
    ws_valid = v; ws_ex = ex; ws_excode = code; ws_bd = bd; ws_pc = pc;
    ws_badvaddr = badv; ws_eret = er; mtc0_we = mt; cp0_addr = addr; cp0_wdata = wd;
    do_ex = v && ex;
    do_er = v && er && !ex;
    do_mt = v && mt && !ex && !er;
    e.addr = addr;
    e.rdata = modelRead(addr);
    e.ex = do_ex || do_er;
    e.target = do_ex ? VEC : m_epc;
    e.hint = modelHasInt();
    sb.push_back(e);
    // Advance the model to the state after the coming clock edge.
    cnt_wr = do_mt && addr == A_COUNT;
    if (do_mt && addr == A_COMP) m_ti = 0;
    else if (m_tick && !cnt_wr && m_count + 32'd1 == m_comp) m_ti = 1;
    if (cnt_wr) m_count = wd;
    else if (m_tick) m_count = m_count + 32'd1;
    m_tick = !m_tick;
    if (do_mt && addr == A_COMP) m_comp = wd;
    if (do_ex) begin
      if (!m_exl) begin
        m_epc = bd ? pc - 32'd4 : pc;
        m_bd = bd;
      end
      m_exl = 1;
      m_code = code;
      if (code == 5'd4 || code == 5'd5) m_badv = badv;
    end else if (do_er) begin
      m_exl = 0;
    end else if (do_mt) begin
      if (addr == A_STAT) begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
      if (addr == A_CAUSE) m_ipsw = wd[9:8];
      if (addr == A_EPC) m_epc = wd;
    end
  endtask

  task automatic idleRead(input logic [4:0] addr);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, addr, 0);
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] wd);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, addr, wd);
  endtask

  task automatic doReset();
    exp_t e;
    @(posedge clk); #1;
    reset = 1;
    ws_valid = 0; ws_ex = 0; ws_excode = 0; ws_bd = 0; ws_pc = 0; ws_badvaddr = 0;
    ws_eret = 0; mtc0_we = 0; cp0_addr = A_COUNT; cp0_wdata = 0;
    modelReset();
    e.addr = A_COUNT; e.rdata = 32'h0; e.ex = 0; e.target = 0; e.hint = 0;
    sb.push_back(e);
  endtask

  logic [4:0] codes [6] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10};
  logic [4:0] addrs [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3, 5'd31, 5'd10};

  initial begin
    reset = 1;
    modelReset();
    doReset();
    idleRead(A_STAT); idleRead(A_CAUSE); idleRead(A_EPC); idleRead(A_COUNT); idleRead(A_BADV);

    // Syscall, then inspect the recorded state.
    applyStimulus(1, 1, 5'd8, 0, 32'hbfc0_1000, 0, 0, 0, A_EPC, 0);
    idleRead(A_EPC); idleRead(A_CAUSE); idleRead(A_STAT);

    // AdEL in a delay slot, then a nested exception that must keep EPC.
    writeReg(A_STAT, 32'h0);
    applyStimulus(1, 1, 5'd4, 1, 32'h0000_1004, 32'h3, 0, 0, A_CAUSE, 0);
    idleRead(A_EPC); idleRead(A_BADV); idleRead(A_CAUSE);
    applyStimulus(1, 1, 5'd8, 0, 32'h0000_2000, 0, 0, 0, A_EPC, 0);
    idleRead(A_EPC);

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, A_STAT, 0);
    idleRead(A_STAT);

    // Timer interrupt path.
    writeReg(A_COMP, 32'd5);
    writeReg(A_COUNT, 32'd0);
    writeReg(A_STAT, 32'h0040_8001);
    repeat (14) idleRead(A_CAUSE);
    writeReg(A_COMP, 32'h100);
    idleRead(A_CAUSE);

    // Count wrap and reset in mid-count.
    writeReg(A_COUNT, 32'hffff_ffff);
    repeat (4) idleRead(A_COUNT);
    doReset();
    idleRead(A_COUNT);

    for (int i = 0; i < 600; i++) begin
      logic v, ex, er, mt, bd;
      logic [4:0] addr, code;
      logic [31:0] wd;
      int r;
      if (i == 300) doReset();
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      ex = (r < 8);
      er = (r >= 8 && r < 14) || ($urandom_range(0, 49) == 0);
      mt = (r >= 14 && r < 55);
      bd = $urandom_range(0, 1) == 1;
      code = codes[$urandom_range(0, 5)];
      addr = addrs[$urandom_range(0, 9)];
      wd = $urandom;
      if (addr == A_COMP && $urandom_range(0, 1) == 1) wd = m_count + 32'($urandom_range(1, 6));
      if (addr == A_STAT && $urandom_range(0, 1) == 1) wd = wd & 32'h0000_ff01;
      applyStimulus(v, ex, code, bd, {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom,
                    er, mt, addr, wd);
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
